div_coproc: RTL and testbench
=============================

Name: div_coproc

Overview:
- Sequential signed 16-bit restoring divider coprocessor that sits directly downstream of the CPU arbiter.
- Consumes the arbiter's start_div pulse and returns div_done.
- While the arbiter grants it the ALU (alu_owner=DIV, ALU forced to SUB), it drives the shared ALU operands and uses the ALU difference for each trial subtraction.
- Quotient and remainder are held for CPU writeback; the destination is selected by the DIV_Q/DIV_R opcode.

Parameters:
- WIDTH, 16, operand and result width; iteration count equals WIDTH (HACK word size).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  start_div pulse from arbiter; sampled only in IDLE.
- sel_rem  input  1  latched at start: 0 = DIV_Q (quotient), 1 = DIV_R (remainder).
- dividend  input  WIDTH  two's-complement numerator (D register); latched at start.
- divisor  input  WIDTH  two's-complement denominator (A/M operand); latched at start.
- alu_x  output  WIDTH  shared-ALU X operand; valid in ITER, otherwise 0.
- alu_y  output  WIDTH  shared-ALU Y operand; valid in ITER, otherwise 0.
- alu_out  input  WIDTH  shared-ALU result, combinational, equal to alu_x - alu_y mod 2^WIDTH.
- busy  output  1  high in every state except IDLE.
- done  output  1  div_done to arbiter; one-cycle pulse.
- quotient  output  WIDTH  signed quotient; held until the next accepted start.
- remainder  output  WIDTH  signed remainder; held until the next accepted start.
- result  output  WIDTH  quotient if latched sel_rem=0, else remainder.
- div_by_zero  output  1  set with done when divisor==0; held until the next accepted start.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE.
  - All outputs 0; all internal registers 0.
  - No done pulse is produced for the aborted operation.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - start=1 latches dividend, divisor and sel_rem.
  - Clears quotient, remainder and div_by_zero, then moves to PREP.
  - start in any other state is ignored; the latched operands are unchanged.
- PREP:
  - Computes unsigned magnitudes |dividend| and |divisor|; 0x8000 maps to magnitude 0x8000.
  - Records q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Clears the partial remainder R and iteration counter.
  - If divisor==0: quotient=0xFFFF, remainder=dividend, div_by_zero=1, next state DONE.
  - Otherwise next state ITER.
- ITER, step k = 0..WIDTH-1, MSB first:
  - T = {R[WIDTH-2:0], next dividend-magnitude bit}.
  - Drive alu_x=T and alu_y=|divisor|.
  - Local unsigned compare T >= |divisor|: if true, R <= alu_out and the quotient bit is 1; else R <= T and the bit is 0.
  - T always fits in WIDTH bits because R < |divisor| <= 2^(WIDTH-1).
  - After step WIDTH-1, next state FIX.
- FIX:
  - quotient = q_neg ? -Qmag : Qmag.
  - remainder = r_neg ? -R : R.
  - Division truncates toward zero; the remainder takes the dividend's sign.
  - Overflow case 0x8000 / 0xFFFF gives quotient 0x8000 (wraps) and remainder 0.
  - Next state DONE.
- DONE:
  - done=1 for exactly this cycle; next state IDLE.
  - busy is still 1 in DONE; the arbiter drops stall on done, and the CPU writes result in this cycle.
- Latency, with cycle 0 = start sampled in IDLE:
  - Normal: PREP in cycle 1, ITER in cycles 2..WIDTH+1, FIX in cycle WIDTH+2, done in cycle WIDTH+3 (cycle 19 for WIDTH=16).
  - Divide-by-zero: done in cycle 2.
- Back-to-back: start may be asserted again in the cycle after DONE (IDLE); no dead cycles are required beyond that.
- quotient, remainder, result and div_by_zero update only in PREP (divide-by-zero) or FIX. They are stable from the done cycle until the next accepted start.

Test Plan:
- 100 / 7, sel_rem=0, start at cycle 0 -> done only in cycle 19; quotient=14, remainder=2, result=14, div_by_zero=0; busy high in cycles 1-19.
- -100 (0xFF9C) / 7, sel_rem=1 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2), result=0xFFFE.
  - Repeat with 100 / -7 -> quotient=0xFFF2, remainder=2.
- 0x8000 / 0xFFFF -> quotient=0x8000, remainder=0.
  - Also 0x8000 / 0x8000 -> quotient=1, remainder=0.
  - In the first ITER cycle of 0x8000 / 3: alu_x=0x0001, alu_y=0x0003.
- 1234 / 0 -> done in cycle 2, quotient=0xFFFF, remainder=1234, div_by_zero=1, ITER never entered, alu_x=alu_y=0 throughout.
- 50 / 5 started; start re-pulsed with 9 / 2 during ITER -> second start ignored, result is quotient=10, remainder=0.
  - Then 9 / 2 started in the cycle after done -> quotient=4, remainder=1.
- rst asserted asynchronously mid-ITER of 77 / 3 -> immediately busy=0, done=0, quotient=remainder=result=0, alu_x=alu_y=0; no done pulse after release.
  - The next start of 77 / 3 gives quotient=25, remainder=2.

Source files
------------

// File: rtl/div_coproc.sv
// div_coproc: sequential signed restoring divider sharing the CPU ALU for trial subtraction.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           start_div pulse from the arbiter, honoured only in IDLE
//   sel_rem         0 selects quotient (DIV_Q), 1 selects remainder (DIV_R) onto result
//   dividend        signed numerator, latched at start
//   divisor         signed denominator, latched at start
//   alu_x, alu_y    shared ALU operands, driven only while iterating, else 0
//   alu_out         shared ALU difference alu_x - alu_y
//   busy            high in every state except IDLE
//   done            one-cycle completion pulse
//   quotient        signed quotient, held until the next accepted start
//   remainder       signed remainder (sign of dividend), held likewise
//   result          quotient or remainder according to the latched sel_rem
//   div_by_zero     set alongside done when the divisor was zero
module div_coproc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel_rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] trial;
    logic             ge;

    // n_q holds the dividend magnitude and shifts left each step; the freed
    // LSB collects quotient bits, so after the last step it is |quotient|.
    assign trial = {r_q[WIDTH-2:0], n_q[WIDTH-1]};
    assign ge    = trial >= m_q;

    assign alu_x       = (state_q == ITER) ? trial : '0;
    assign alu_y       = (state_q == ITER) ? m_q : '0;
    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign result      = sel_q ? rem_q : quo_q;
    assign div_by_zero = dbz_q;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sel_d   = sel_q;
        n_d     = n_q;
        m_d     = m_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (start) begin
                dvd_d   = dividend;
                dvs_d   = divisor;
                sel_d   = sel_rem;
                quo_d   = '0;
                rem_d   = '0;
                dbz_d   = 1'b0;
                state_d = PREP;
            end
            PREP: begin
                // Negating 0x8000 yields 0x8000, which is its correct unsigned magnitude.
                n_d    = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
                m_d    = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
                qneg_d = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
                rneg_d = dvd_q[WIDTH-1];
                r_d    = '0;
                cnt_d  = '0;
                if (dvs_q == '0) begin
                    quo_d   = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                r_d   = ge ? alu_out : trial;
                n_d   = {n_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : ITER;
            end
            FIX: begin
                quo_d   = qneg_q ? -n_q : n_q;
                rem_d   = rneg_q ? -r_q : r_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sel_q   <= 1'b0;
            n_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sel_q   <= sel_d;
            n_q     <= n_d;
            m_q     <= m_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_div_coproc.sv
// tb_div_coproc: scoreboard bench for div_coproc with directed operand vectors.
module tb_div_coproc;
    logic        clk, rst, start, sel_rem;
    logic [15:0] dividend, divisor, alu_x, alu_y, alu_out;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder, result;

    typedef struct {
        string       name;
        logic [15:0] q;
        logic [15:0] r;
        logic [15:0] res;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    assign alu_out = alu_x - alu_y;

    div_coproc #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sel_rem(sel_rem),
        .dividend(dividend), .divisor(divisor),
        .alu_x(alu_x), .alu_y(alu_y), .alu_out(alu_out),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .result(result), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_q"}, quotient, e.q);
                chk({e.name, "_r"}, remainder, e.r);
                chk({e.name, "_res"}, result, e.res);
                chk({e.name, "_dbz"}, div_by_zero, e.dbz);
            end
        end
    end

    // Issues start in the current cycle (cycle 0); returns in cycle 1.
    task automatic start_op(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic [15:0] eq, input logic [15:0] er,
                            input logic ed, input bit push);
        exp_t e;
        dividend = a;
        divisor  = b;
        sel_rem  = s;
        start    = 1'b1;
        if (push) begin
            e.name = name; e.q = eq; e.r = er; e.res = s ? er : eq; e.dbz = ed;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Walks cycles from c0 until done, checking busy and latency; returns in the cycle after done.
    task automatic wait_done(input string name, input int c0, input int lat, input bit zero_alu);
        int  c;
        bit  seen;
        c    = c0;
        seen = 1'b0;
        while (!seen && c <= 40) begin
            chk({name, "_busy"}, busy, 1);
            if (zero_alu) begin
                chk({name, "_alux0"}, alu_x, 0);
                chk({name, "_aluy0"}, alu_y, 0);
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                chk({name, "_latency"}, c, lat);
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done by cycle %0d expected done in cycle %0d", name, c, lat);
        end
        @(posedge clk); #1;
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_done"}, done, 0);
    endtask

    initial begin
        int dcount;
        rst = 1'b1; start = 1'b0; sel_rem = 1'b0; dividend = '0; divisor = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_res", result, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_alux", alu_x, 0);
        chk("rst_aluy", alu_y, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        start_op("p100_7", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 1'b1);
        wait_done("p100_7", 1, 19, 1'b0);
        chk("p100_7_held_q", quotient, 14);

        start_op("n100_7", 16'hFF9C, 16'd7, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b1);
        wait_done("n100_7", 1, 19, 1'b0);

        start_op("p100_n7", 16'd100, 16'hFFF9, 1'b0, 16'hFFF2, 16'd2, 1'b0, 1'b1);
        wait_done("p100_n7", 1, 19, 1'b0);

        start_op("min_m1", 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1);
        wait_done("min_m1", 1, 19, 1'b0);

        start_op("min_min", 16'h8000, 16'h8000, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b1);
        wait_done("min_min", 1, 19, 1'b0);

        start_op("min_3", 16'h8000, 16'd3, 1'b0, 16'hD556, 16'hFFFE, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("min_3_iter0_alux", alu_x, 16'h0001);
        chk("min_3_iter0_aluy", alu_y, 16'h0003);
        wait_done("min_3", 2, 19, 1'b0);

        start_op("dbz", 16'd1234, 16'd0, 1'b0, 16'hFFFF, 16'd1234, 1'b1, 1'b1);
        chk("dbz_prep_alux", alu_x, 0);
        wait_done("dbz", 1, 2, 1'b1);

        start_op("p50_5", 16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 1'b0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        dividend = 16'd9; divisor = 16'd2; sel_rem = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("p50_5", 5, 19, 1'b0);

        start_op("p9_2", 16'd9, 16'd2, 1'b1, 16'd4, 16'd1, 1'b0, 1'b1);
        wait_done("p9_2", 1, 19, 1'b0);

        start_op("abort", 16'd77, 16'd3, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_res", result, 0);
        chk("abort_alux", alu_x, 0);
        chk("abort_aluy", alu_y, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        chk("abort_no_done", dcount, 0);

        start_op("p77_3", 16'd77, 16'd3, 1'b0, 16'd25, 16'd2, 1'b0, 1'b1);
        wait_done("p77_3", 1, 19, 1'b0);

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
